// File: rtl/pwm_reg_pkg.sv
// Shared constants for the PWM register bank: address map, CTRL bits, key codes, lock states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pwm_reg_pkg;

    // Global register addresses
    localparam int ADDR_CTRL    = 8'h00;
    localparam int ADDR_PSC     = 8'h01;
    localparam int ADDR_ARR     = 8'h02;
    localparam int ADDR_STATUS  = 8'h03;
    localparam int ADDR_IER     = 8'h04;
    localparam int ADDR_KEY     = 8'h05;

    // Per-channel register window: base + stride*n + offset
    localparam int ADDR_CH_BASE = 8'h10;
    localparam int CH_STRIDE    = 4;
    localparam int CH_OFF_START = 0;
    localparam int CH_OFF_END   = 1;
    localparam int CH_OFF_CFG   = 2;
    localparam int CH_OFF_DTG   = 3;

    // CTRL bit positions
    localparam int CTRL_CEN     = 0;
    localparam int CTRL_ARPE    = 1;
    localparam int CTRL_UG      = 2;

    // Write-protect key bytes (compared against the low byte of a KEY write)
    localparam logic [7:0] KEY_LOCK = 8'hCC;
    localparam logic [7:0] KEY1     = 8'hA5;
    localparam logic [7:0] KEY2     = 8'h5A;

    // Deadtime comes out of reset at one tick so the outputs never overlap
    localparam logic [7:0] DTG_RST  = 8'h01;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_KEY1     = 2'd2
    } lock_state_t;

    // Absolute address of a channel register
    function automatic int ch_addr(input int ch, input int off);
        return ADDR_CH_BASE + CH_STRIDE * ch + off;
    endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// One preload/active register pair: bus writes land in preload, active drives the PWM core.
// Latency: preload 1 cycle after write; active 1 cycle after write (arpe=0) or after update (arpe=1).
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
module pwm_shadow_reg #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] data,
    input  logic         arpe,
    input  logic         update,
    output logic [W-1:0] preload,
    output logic [W-1:0] active
);

    // Preload captures writes; active either tracks preload or reloads on an update.
    // An update that coincides with a write transfers the old preload, the new
    // value waits for the next update.
    always_ff @(posedge clk) begin
        if (rst) begin
            preload <= RST_VAL;
            active  <= RST_VAL;
        end else begin
            if (wr) begin
                preload <= data;
            end
            if (update) begin
                active <= preload;
            end else if (!arpe) begin
                active <= wr ? data : preload;
            end
        end
    end

endmodule

// File: rtl/pwm_register_bank.sv
// PWM configuration bank: preload/active register sets, write-protect keys, W1C status with irq, registered reads.
// Latency: reads 1 cycle; active outputs 1 cycle after write (ARPE=0) or after uev/UG (ARPE=1); irq 1 cycle after flag.
// Backpressure: none; bus accepts a read and/or write every cycle, protected writes are silently dropped.
module pwm_register_bank
    import pwm_reg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic                    clk_psc_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    uev_i,
    input  logic [NUM_CH-1:0]       cc_evt_i,
    output logic                    cen_o,
    output logic [WIDTH-1:0]        psc_o,
    output logic [WIDTH-1:0]        arr_o,
    output logic [NUM_CH*WIDTH-1:0] cmp_start_o,
    output logic [NUM_CH*WIDTH-1:0] cmp_end_o,
    output logic [NUM_CH*WIDTH-1:0] cfg_o,
    output logic [NUM_CH*8-1:0]     dtg_o,
    output logic                    update_o,
    output logic                    irq_o,
    output logic                    locked_o
);

    lock_state_t       lock_q;
    lock_state_t       lock_d;

    logic              cen_q;
    logic              arpe_q;
    logic              update_q;
    logic              irq_q;
    logic [NUM_CH:0]   status_q;
    logic [NUM_CH:0]   ier_q;
    logic [NUM_CH:0]   status_set;
    logic [NUM_CH:0]   status_clr;
    logic [WIDTH-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic [WIDTH-1:0]  rd_mux;

    logic [WIDTH-1:0]  psc_pre;
    logic [WIDTH-1:0]  arr_pre;
    logic [WIDTH-1:0]  start_pre [NUM_CH];
    logic [WIDTH-1:0]  end_pre   [NUM_CH];
    logic [WIDTH-1:0]  cfg_pre   [NUM_CH];
    logic [7:0]        dtg_pre   [NUM_CH];

    logic              wr_ctrl;
    logic              wr_psc;
    logic              wr_arr;
    logic              wr_status;
    logic              wr_ier;
    logic              wr_key;
    logic              wr_open;
    logic              ug;
    logic              update;
    logic [7:0]        key_byte;

    // ------------------------------------------------------------------
    // Global address decode
    // ------------------------------------------------------------------
    assign wr_ctrl   = wr_en_i && (addr_i == ADDR_W'(ADDR_CTRL));
    assign wr_psc    = wr_en_i && (addr_i == ADDR_W'(ADDR_PSC));
    assign wr_arr    = wr_en_i && (addr_i == ADDR_W'(ADDR_ARR));
    assign wr_status = wr_en_i && (addr_i == ADDR_W'(ADDR_STATUS));
    assign wr_ier    = wr_en_i && (addr_i == ADDR_W'(ADDR_IER));
    assign wr_key    = wr_en_i && (addr_i == ADDR_W'(ADDR_KEY));
    assign key_byte  = wr_data_i[7:0];

    // Timing registers only accept writes in the fully unlocked state; KEY1 counts as locked.
    assign wr_open   = (lock_q == ST_UNLOCKED);

    // UG is always writable and behaves like a software uev.
    assign ug        = wr_ctrl && wr_data_i[CTRL_UG];
    assign update    = arpe_q && (uev_i || ug);

    // ------------------------------------------------------------------
    // Preload/active pairs
    // ------------------------------------------------------------------
    pwm_shadow_reg #(
        .W       (WIDTH),
        .RST_VAL ({WIDTH{1'b0}})
    ) u_psc (
        .clk     (clk_psc_i),
        .rst     (rst_i),
        .wr      (wr_psc && wr_open),
        .data    (wr_data_i),
        .arpe    (arpe_q),
        .update  (update),
        .preload (psc_pre),
        .active  (psc_o)
    );

    pwm_shadow_reg #(
        .W       (WIDTH),
        .RST_VAL ({WIDTH{1'b1}})
    ) u_arr (
        .clk     (clk_psc_i),
        .rst     (rst_i),
        .wr      (wr_arr && wr_open),
        .data    (wr_data_i),
        .arpe    (arpe_q),
        .update  (update),
        .preload (arr_pre),
        .active  (arr_o)
    );

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic wr_start;
        logic wr_end;
        logic wr_cfg;
        logic wr_dtg;

        assign wr_start = wr_en_i && wr_open && (addr_i == ADDR_W'(ch_addr(n, CH_OFF_START)));
        assign wr_end   = wr_en_i && wr_open && (addr_i == ADDR_W'(ch_addr(n, CH_OFF_END)));
        assign wr_cfg   = wr_en_i && wr_open && (addr_i == ADDR_W'(ch_addr(n, CH_OFF_CFG)));
        assign wr_dtg   = wr_en_i && wr_open && (addr_i == ADDR_W'(ch_addr(n, CH_OFF_DTG)));

        pwm_shadow_reg #(
            .W       (WIDTH),
            .RST_VAL ({WIDTH{1'b0}})
        ) u_start (
            .clk     (clk_psc_i),
            .rst     (rst_i),
            .wr      (wr_start),
            .data    (wr_data_i),
            .arpe    (arpe_q),
            .update  (update),
            .preload (start_pre[n]),
            .active  (cmp_start_o[n*WIDTH +: WIDTH])
        );

        pwm_shadow_reg #(
            .W       (WIDTH),
            .RST_VAL ({WIDTH{1'b0}})
        ) u_end (
            .clk     (clk_psc_i),
            .rst     (rst_i),
            .wr      (wr_end),
            .data    (wr_data_i),
            .arpe    (arpe_q),
            .update  (update),
            .preload (end_pre[n]),
            .active  (cmp_end_o[n*WIDTH +: WIDTH])
        );

        pwm_shadow_reg #(
            .W       (WIDTH),
            .RST_VAL ({WIDTH{1'b0}})
        ) u_cfg (
            .clk     (clk_psc_i),
            .rst     (rst_i),
            .wr      (wr_cfg),
            .data    (wr_data_i),
            .arpe    (arpe_q),
            .update  (update),
            .preload (cfg_pre[n]),
            .active  (cfg_o[n*WIDTH +: WIDTH])
        );

        pwm_shadow_reg #(
            .W       (8),
            .RST_VAL (DTG_RST)
        ) u_dtg (
            .clk     (clk_psc_i),
            .rst     (rst_i),
            .wr      (wr_dtg),
            .data    (wr_data_i[7:0]),
            .arpe    (arpe_q),
            .update  (update),
            .preload (dtg_pre[n]),
            .active  (dtg_o[n*8 +: 8])
        );
    end

    // ------------------------------------------------------------------
    // Control, status and interrupt
    // ------------------------------------------------------------------
    assign status_set = {cc_evt_i, uev_i || ug};
    assign status_clr = wr_status ? wr_data_i[NUM_CH:0] : '0;

    // CTRL/STATUS/IER state; set beats W1C, irq looks at the flags already stored.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            cen_q    <= 1'b0;
            arpe_q   <= 1'b0;
            status_q <= '0;
            ier_q    <= '0;
            irq_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                cen_q <= wr_data_i[CTRL_CEN];
                if (wr_open) begin
                    arpe_q <= wr_data_i[CTRL_ARPE];
                end
            end
            if (wr_ier) begin
                ier_q <= wr_data_i[NUM_CH:0];
            end
            status_q <= (status_q & ~status_clr) | status_set;
            irq_q    <= |(status_q & ier_q);
            update_q <= update;
        end
    end

    // ------------------------------------------------------------------
    // Write-protect key FSM
    // ------------------------------------------------------------------

    // Lock state register.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            lock_q <= ST_UNLOCKED;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Lock next-state: 0xCC locks from anywhere; 0xA5 then 0x5A back-to-back unlocks.
    always_comb begin
        lock_d = lock_q;
        if (wr_key && (key_byte == KEY_LOCK)) begin
            lock_d = ST_LOCKED;
        end else begin
            case (lock_q)
                ST_LOCKED: begin
                    if (wr_key && (key_byte == KEY1)) begin
                        lock_d = ST_KEY1;
                    end
                end
                ST_KEY1: begin
                    if (wr_en_i) begin
                        lock_d = (wr_key && (key_byte == KEY2)) ? ST_UNLOCKED : ST_LOCKED;
                    end
                end
                default: begin
                    lock_d = lock_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Read mux over preload copies; sees pre-write state for same-cycle read+write.
    always_comb begin
        rd_mux = '0;
        if (addr_i == ADDR_W'(ADDR_CTRL)) begin
            rd_mux = WIDTH'({arpe_q, cen_q});
        end else if (addr_i == ADDR_W'(ADDR_PSC)) begin
            rd_mux = psc_pre;
        end else if (addr_i == ADDR_W'(ADDR_ARR)) begin
            rd_mux = arr_pre;
        end else if (addr_i == ADDR_W'(ADDR_STATUS)) begin
            rd_mux = WIDTH'(status_q);
        end else if (addr_i == ADDR_W'(ADDR_IER)) begin
            rd_mux = WIDTH'(ier_q);
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr_i == ADDR_W'(ch_addr(n, CH_OFF_START))) rd_mux = start_pre[n];
            if (addr_i == ADDR_W'(ch_addr(n, CH_OFF_END)))   rd_mux = end_pre[n];
            if (addr_i == ADDR_W'(ch_addr(n, CH_OFF_CFG)))   rd_mux = cfg_pre[n];
            if (addr_i == ADDR_W'(ch_addr(n, CH_OFF_DTG)))   rd_mux = WIDTH'(dtg_pre[n]);
        end
    end

    // Registered read data; holds its last value between reads.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign cen_o      = cen_q;
    assign update_o   = update_q;
    assign irq_o      = irq_q;
    assign locked_o   = (lock_q != ST_UNLOCKED);

endmodule

// File: tb/tb_pwm_register_bank.sv
// Self-checking bench for pwm_register_bank: directed scenarios plus randomized traffic vs a register-file model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pwm_register_bank;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 8;
    localparam int NREG   = 2 + 4 * NUM_CH;   // PSC, ARR, then start/end/cfg/dtg per channel

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wr_en;
    logic                    rd_en;
    logic [ADDR_W-1:0]       addr;
    logic [WIDTH-1:0]        wr_data;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_valid;
    logic                    uev;
    logic [NUM_CH-1:0]       cc_evt;
    logic                    cen;
    logic [WIDTH-1:0]        psc;
    logic [WIDTH-1:0]        arr;
    logic [NUM_CH*WIDTH-1:0] cmp_start;
    logic [NUM_CH*WIDTH-1:0] cmp_end;
    logic [NUM_CH*WIDTH-1:0] cfg;
    logic [NUM_CH*8-1:0]     dtg;
    logic                    update;
    logic                    irq;
    logic                    locked;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_register_bank #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_psc_i   (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .rd_en_i     (rd_en),
        .addr_i      (addr),
        .wr_data_i   (wr_data),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .uev_i       (uev),
        .cc_evt_i    (cc_evt),
        .cen_o       (cen),
        .psc_o       (psc),
        .arr_o       (arr),
        .cmp_start_o (cmp_start),
        .cmp_end_o   (cmp_end),
        .cfg_o       (cfg),
        .dtg_o       (dtg),
        .update_o    (update),
        .irq_o       (irq),
        .locked_o    (locked)
    );

    // ---------------- reference model ----------------
    logic [15:0] m_pre [NREG];
    logic [15:0] m_act [NREG];
    bit          m_cen, m_arpe, m_upd, m_irq, m_rd_vld;
    logic [4:0]  m_status, m_ier;
    int          m_lock;            // 0 unlocked, 1 locked, 2 first key seen
    logic [15:0] m_rd_data;

    function automatic int reg_index(input logic [7:0] a);
        if (a == 8'h01) return 0;
        if (a == 8'h02) return 1;
        if (int'(a) >= 16 && int'(a) < 16 + 4 * NUM_CH) return 2 + int'(a) - 16;
        return -1;
    endfunction

    function automatic bit is_dtg(input int idx);
        return (idx >= 2) && ((idx - 2) % 4 == 3);
    endfunction

    function automatic logic [15:0] reset_val(input int idx);
        if (idx == 1) return 16'hFFFF;
        if (is_dtg(idx)) return 16'h0001;
        return 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [7:0] a);
        int idx;
        idx = reg_index(a);
        if (idx >= 0) return m_pre[idx];
        if (a == 8'h00) return {14'd0, m_arpe, m_cen};
        if (a == 8'h03) return {11'd0, m_status};
        if (a == 8'h04) return {11'd0, m_ier};
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_pre[i] = reset_val(i);
            m_act[i] = reset_val(i);
        end
        m_cen = 0; m_arpe = 0; m_upd = 0; m_irq = 0; m_rd_vld = 0;
        m_status = '0; m_ier = '0; m_lock = 0; m_rd_data = '0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [7:0] a, input logic [15:0] d,
                              input bit u, input logic [3:0] cc);
        int          idx;
        bit          ug, upd;
        logic [15:0] new_pre [NREG];
        if (r) m_rd_data = model_read(a);
        m_rd_vld = r;
        ug  = w && (a == 8'h00) && d[2];
        upd = m_arpe && (u || ug);
        idx = reg_index(a);
        new_pre = m_pre;
        if (w && idx >= 0 && m_lock == 0) new_pre[idx] = is_dtg(idx) ? {8'h00, d[7:0]} : d;
        for (int i = 0; i < NREG; i++) begin
            if (upd)        m_act[i] = m_pre[i];
            else if (!m_arpe) m_act[i] = new_pre[i];
        end
        m_pre    = new_pre;
        m_upd    = upd;
        m_irq    = |(m_status & m_ier);
        m_status = (m_status & ~((w && a == 8'h03) ? d[4:0] : 5'd0)) | {cc, u | ug};
        if (w && a == 8'h04) m_ier = d[4:0];
        if (w && a == 8'h00) begin
            m_cen = d[0];
            if (m_lock == 0) m_arpe = d[1];
        end
        if (w && a == 8'h05 && d[7:0] == 8'hCC)                   m_lock = 1;
        else if (m_lock == 1 && w && a == 8'h05 && d[7:0] == 8'hA5) m_lock = 2;
        else if (m_lock == 2 && w) m_lock = (a == 8'h05 && d[7:0] == 8'h5A) ? 0 : 1;
    endtask

    // ---------------- drivers ----------------
    task automatic cyc(input bit w, input bit r, input logic [7:0] a, input logic [15:0] d,
                       input bit u, input logic [3:0] cc, input bit rs);
        wr_en = w; rd_en = r; addr = a; wr_data = d; uev = u; cc_evt = cc; rst = rs;
        if (rs) model_reset();
        else    model_step(w, r, a, d, u, cc);
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; uev = 0; cc_evt = '0; rst = 0;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [15:0] d);
        cyc(1, 0, a, d, 0, '0, 0);
    endtask

    task automatic do_rd(input logic [7:0] a);
        cyc(0, 1, a, 16'h0, 0, '0, 0);
    endtask

    task automatic do_idle();
        cyc(0, 0, 8'h00, 16'h0, 0, '0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0]  a;
        logic [15:0] exp_v;
        cyc(0, 0, 8'h00, 16'h0, 0, '0, 1);
        cyc(0, 0, 8'h00, 16'h0, 0, '0, 1);
        total++; if (arr !== 16'hFFFF) begin bad++; $display("FAIL reset_arr got=%h want=ffff", arr); end
        total++; if (psc !== 16'h0) begin bad++; $display("FAIL reset_psc got=%h want=0", psc); end
        total++; if (dtg !== 32'h01010101) begin bad++; $display("FAIL reset_dtg got=%h want=01010101", dtg); end
        total++; if ((cmp_start | cmp_end | cfg) !== '0) begin bad++; $display("FAIL reset_cmp got=%h/%h/%h want=0", cmp_start, cmp_end, cfg); end
        total++; if ({cen, update, irq, locked, rd_valid} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {cen, update, irq, locked, rd_valid}); end
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        for (int i = 0; i < 40; i++) begin
            a = (i < 8) ? 8'(i) : 8'(i + 8);      // 0x00..0x07, then 0x10..0x2F
            exp_v = (a == 8'h02) ? 16'hFFFF :
                    (a >= 8'h10 && a < 8'h20 && a[1:0] == 2'd3) ? 16'h0001 : 16'h0000;
            do_rd(a);
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL reset_rd_valid addr=%h got=%b want=1", a, rd_valid); end
            total++; if (rd_data !== exp_v) begin bad++; $display("FAIL reset_read addr=%h got=%h want=%h", a, rd_data, exp_v); end
        end
        do_idle();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_idle got=%b want=0", rd_valid); end
    endtask

    task automatic test_arpe0();
        do_wr(8'h18, 16'h0123);
        total++; if (cmp_start[47:32] !== 16'h0123) begin bad++; $display("FAIL arpe0_start got=%h want=0123", cmp_start[47:32]); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL arpe0_update got=%b want=0", update); end
        do_wr(8'h1F, 16'hABCD);                    // dtg keeps only the low byte
        do_rd(8'h1F);
        total++; if (dtg[31:24] !== 8'hCD || rd_data !== 16'h00CD) begin bad++; $display("FAIL dtg_narrow got=%h/%h want=cd/00cd", dtg[31:24], rd_data); end
    endtask

    task automatic test_preload();
        do_wr(8'h00, 16'h0002);                    // ARPE=1
        do_wr(8'h02, 16'h03E8);
        total++; if (arr !== 16'hFFFF) begin bad++; $display("FAIL preload_hold got=%h want=ffff", arr); end
        cyc(0, 0, 8'h00, 16'h0, 1, '0, 0);
        total++; if (arr !== 16'h03E8 || update !== 1'b1) begin bad++; $display("FAIL preload_uev got=%h/%b want=03e8/1", arr, update); end
        do_idle();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL update_pulse got=%b want=0", update); end
        cyc(1, 0, 8'h02, 16'h07D0, 1, '0, 0);      // write coincident with uev
        do_idle();
        total++; if (arr !== 16'h03E8) begin bad++; $display("FAIL preload_coincident got=%h want=03e8", arr); end
        cyc(0, 0, 8'h00, 16'h0, 1, '0, 0);
        total++; if (arr !== 16'h07D0) begin bad++; $display("FAIL preload_next got=%h want=07d0", arr); end
        do_wr(8'h11, 16'h0055);
        do_wr(8'h00, 16'h0006);                    // ARPE=1 plus UG
        total++; if (cmp_end[15:0] !== 16'h0055 || update !== 1'b1) begin bad++; $display("FAIL ug_update got=%h/%b want=0055/1", cmp_end[15:0], update); end
        do_rd(8'h00);
        total++; if (rd_data !== 16'h0002) begin bad++; $display("FAIL ctrl_read got=%h want=0002", rd_data); end
    endtask

    task automatic test_lock();
        do_wr(8'h00, 16'h0000);                    // ARPE=0, CEN=0
        do_wr(8'h05, 16'h00CC);
        do_wr(8'h01, 16'h0005);
        do_rd(8'h01);
        total++; if (rd_data !== 16'h0 || locked !== 1'b1) begin bad++; $display("FAIL lock_psc got=%h/%b want=0000/1", rd_data, locked); end
        do_wr(8'h00, 16'h0003);                    // CEN passes, ARPE dropped
        do_rd(8'h00);
        total++; if (cen !== 1'b1 || rd_data !== 16'h0001) begin bad++; $display("FAIL lock_ctrl got=%b/%h want=1/0001", cen, rd_data); end
        do_wr(8'h05, 16'h00A5);
        do_wr(8'h04, 16'h0001);                    // breaks sequence, still applied
        do_rd(8'h04);
        total++; if (rd_data !== 16'h0001 || locked !== 1'b1) begin bad++; $display("FAIL lock_ier got=%h/%b want=0001/1", rd_data, locked); end
        do_wr(8'h05, 16'h005A);                    // must not unlock from LOCKED
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_key2_only got=%b want=1", locked); end
        do_wr(8'h05, 16'h00A5);
        do_wr(8'h05, 16'h005A);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL unlock got=%b want=0", locked); end
        do_wr(8'h01, 16'h0005);
        total++; if (psc !== 16'h0005) begin bad++; $display("FAIL unlock_psc got=%h want=0005", psc); end
    endtask

    task automatic test_status_irq();
        do_wr(8'h03, 16'h001F);
        do_wr(8'h04, 16'h0002);
        do_idle();
        cyc(0, 0, 8'h00, 16'h0, 0, 4'b0001, 0);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", irq); end
        do_rd(8'h03);
        total++; if (rd_data !== 16'h0002 || irq !== 1'b1) begin bad++; $display("FAIL status_set got=%h/%b want=0002/1", rd_data, irq); end
        cyc(1, 0, 8'h03, 16'h0002, 0, 4'b0001, 0); // set wins over W1C
        do_rd(8'h03);
        total++; if (rd_data !== 16'h0002 || irq !== 1'b1) begin bad++; $display("FAIL set_wins got=%h/%b want=0002/1", rd_data, irq); end
        do_wr(8'h03, 16'h0002);
        do_idle();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq); end
    endtask

    task automatic test_back_to_back();
        do_wr(8'h01, 16'h0011);
        cyc(1, 1, 8'h01, 16'h0022, 0, '0, 0);
        total++; if (rd_data !== 16'h0011) begin bad++; $display("FAIL rw_same got=%h want=0011", rd_data); end
        do_rd(8'h01);
        do_idle();
        total++; if (rd_data !== 16'h0022 || rd_valid !== 1'b0) begin bad++; $display("FAIL rd_hold got=%h/%b want=0022/0", rd_data, rd_valid); end
    endtask

    task automatic test_reset_abort();
        do_wr(8'h00, 16'h0002);
        do_wr(8'h01, 16'h0099);
        do_wr(8'h00, 16'h0006);
        cyc(0, 0, 8'h00, 16'h0, 0, '0, 1);
        total++; if (psc !== 16'h0 || arr !== 16'hFFFF || update !== 1'b0 || cen !== 1'b0) begin bad++; $display("FAIL reset_after_ug got=%h/%h/%b want=0000/ffff/0", psc, arr, update); end
        do_wr(8'h00, 16'h0002);
        do_wr(8'h01, 16'h0099);
        cyc(1, 0, 8'h00, 16'h0006, 0, '0, 1);      // UG write under reset
        total++; if (psc !== 16'h0 || update !== 1'b0) begin bad++; $display("FAIL reset_with_ug got=%h/%b want=0000/0", psc, update); end
        do_idle();
        total++; if (update !== 1'b0 || dtg !== 32'h01010101) begin bad++; $display("FAIL reset_no_pulse got=%b/%h want=0/01010101", update, dtg); end
    endtask

    task automatic test_random();
        logic [7:0]  tab [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05, 8'h05,
                                  8'h10, 8'h13, 8'h16, 8'h1A, 8'h1F, 8'h06, 8'h20, 8'hFF};
        logic [7:0]  a;
        logic [15:0] d;
        logic [63:0] e_start, e_end, e_cfg;
        logic [31:0] e_dtg;
        bit          w, r, u, rs;
        logic [3:0]  cc;
        cyc(0, 0, 8'h00, 16'h0, 0, '0, 1);
        for (int n = 0; n < 1500; n++) begin
            a  = tab[$urandom_range(0, 15)];
            d  = 16'($urandom);
            if (a == 8'h05) begin
                case ($urandom_range(0, 3))
                    0: d[7:0] = 8'hCC;
                    1: d[7:0] = 8'hA5;
                    2: d[7:0] = 8'h5A;
                    default: ;
                endcase
            end
            w  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 9) < 4);
            u  = ($urandom_range(0, 7) == 0);
            cc = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            rs = ($urandom_range(0, 99) == 0);
            cyc(w, r, a, d, u, cc, rs);
            for (int c = 0; c < NUM_CH; c++) begin
                e_start[c*16 +: 16] = m_act[2 + 4*c];
                e_end[c*16 +: 16]   = m_act[3 + 4*c];
                e_cfg[c*16 +: 16]   = m_act[4 + 4*c];
                e_dtg[c*8 +: 8]     = m_act[5 + 4*c][7:0];
            end
            total++; if (psc !== m_act[0] || arr !== m_act[1]) begin bad++; $display("FAIL rnd_timer n=%0d got=%h/%h want=%h/%h", n, psc, arr, m_act[0], m_act[1]); end
            total++; if (cmp_start !== e_start || cmp_end !== e_end) begin bad++; $display("FAIL rnd_cmp n=%0d got=%h/%h want=%h/%h", n, cmp_start, cmp_end, e_start, e_end); end
            total++; if (cfg !== e_cfg || dtg !== e_dtg) begin bad++; $display("FAIL rnd_cfg n=%0d got=%h/%h want=%h/%h", n, cfg, dtg, e_cfg, e_dtg); end
            total++; if ({cen, update, irq, locked} !== {m_cen, m_upd, m_irq, m_lock != 0}) begin bad++; $display("FAIL rnd_flags n=%0d got=%b want=%b", n, {cen, update, irq, locked}, {m_cen, m_upd, m_irq, m_lock != 0}); end
            total++; if (rd_valid !== m_rd_vld || rd_data !== m_rd_data) begin bad++; $display("FAIL rnd_read n=%0d got=%b/%h want=%b/%h", n, rd_valid, rd_data, m_rd_vld, m_rd_data); end
        end
    endtask

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; addr = '0; wr_data = '0; uev = 0; cc_evt = '0;
        model_reset();
        test_reset();
        test_arpe0();
        test_preload();
        test_lock();
        test_status_irq();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
